// File: rtl/stream_packer.sv
// stream_packer: packs WORDS narrow words from an unstallable source into a valid/ready payload stream.
// Ports: clk, reset_n (async active-low), enable (global freeze when low), word_valid/word_in (source strobe),
//   out_valid/out_ready/payload_out (master port, word k at [k*WORD_WIDTH +: WORD_WIDTH]),
//   overflow (sticky drop flag) / clear_overflow, flush (only when STREAM_PACKER_FLUSH_EN is defined).
module stream_packer #(
  parameter int WORD_WIDTH = 16,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        word_valid,
  input  logic [WORD_WIDTH-1:0]       word_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_WIDTH*WORDS-1:0] payload_out,
  output logic                        overflow,
`ifdef STREAM_PACKER_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        clear_overflow
);
  localparam int CW = $clog2(WORDS);
  localparam int PW = WORD_WIDTH * WORDS;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] acc_q, acc_d, payload_q, payload_d, acc_w, done_acc;
  logic          pending_q, pending_d, out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic          take_out, take_word, done, slot_free;
  logic [CW:0]   filled;
  always_comb begin
    take_out  = enable & out_valid_q & out_ready;
    take_word = enable & word_valid & ~pending_q;
    slot_free = ~out_valid_q | take_out;
    acc_w = acc_q;
    for (int k = 0; k < WORDS; k++)
      if (take_word && count_q == CW'(k)) acc_w[k*WORD_WIDTH +: WORD_WIDTH] = word_in;
    filled   = {1'b0, count_q} + {{CW{1'b0}}, take_word};
    done     = filled == (CW+1)'(WORDS);
    done_acc = acc_w;
`ifdef STREAM_PACKER_FLUSH_EN
    // A flush completes whatever is held (including this cycle's word), zeroing the unfilled upper words.
    if (enable && flush && !pending_q && |filled) begin
      done = 1'b1;
      for (int k = 0; k < WORDS; k++)
        if ((CW+1)'(k) >= filled) done_acc[k*WORD_WIDTH +: WORD_WIDTH] = '0;
    end
`endif
    count_d     = done ? '0 : filled[CW-1:0];
    acc_d       = done_acc;
    payload_d   = payload_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    // Completion and a pending drain are exclusive: nothing is accepted while pending.
    if (pending_q && take_out) begin
      payload_d = acc_q;
      pending_d = 1'b0;
    end else if (done) begin
      payload_d   = slot_free ? done_acc : payload_q;
      out_valid_d = slot_free ? 1'b1 : out_valid_q;
      pending_d   = ~slot_free;
    end else if (take_out) begin
      out_valid_d = 1'b0;
    end
    overflow_d = (enable & word_valid & pending_q) | (overflow_q & ~(enable & clear_overflow));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      acc_q       <= '0;
      payload_q   <= '0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      payload_q   <= payload_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign payload_out = payload_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed checks of stream_packer with WORD_WIDTH=16, WORDS=4.
module tb_stream_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        word_valid = 1'b0;
  logic [15:0] word_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] payload_out;
  logic        overflow;
  logic        clear_overflow = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
  logic        flush = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  stream_packer #(.WORD_WIDTH(16), .WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .word_valid(word_valid), .word_in(word_in),
    .out_valid(out_valid), .out_ready(out_ready), .payload_out(payload_out), .overflow(overflow),
`ifdef STREAM_PACKER_FLUSH_EN
    .flush(flush),
`endif
    .clear_overflow(clear_overflow)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] w);
    word_valid = 1'b1;
    word_in = w;
    step();
    word_valid = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #2;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_payload", payload_out, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    #10 reset_n = 1'b1;
    // basic packing with consumer ready
    out_ready = 1'b1;
    send(16'h1111); send(16'h2222); send(16'h3333);
    chk("s1_not_yet", {63'd0, out_valid}, 64'd0);
    send(16'h4444);
    chk("s1_valid", {63'd0, out_valid}, 64'd1);
    chk("s1_payload", payload_out, 64'h4444_3333_2222_1111);
    step();
    chk("s1_drop", {63'd0, out_valid}, 64'd0);
    // second payload held pending while consumer stalls
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(i));
    chk("s2_valid", {63'd0, out_valid}, 64'd1);
    chk("s2_payload1", payload_out, 64'h0004_0003_0002_0001);
    for (int i = 5; i <= 8; i++) send(16'(i));
    chk("s2_hold", payload_out, 64'h0004_0003_0002_0001);
    chk("s2_no_ovf", {63'd0, overflow}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("s2_b2b_valid", {63'd0, out_valid}, 64'd1);
    chk("s2_payload2", payload_out, 64'h0008_0007_0006_0005);
    step();
    chk("s2_drained", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    // overflow set/clear
    for (int i = 8'h11; i <= 8'h18; i++) send(16'(i));
    chk("s3_no_ovf_yet", {63'd0, overflow}, 64'd0);
    send(16'h0019);
    chk("s3_ovf", {63'd0, overflow}, 64'd1);
    clear_overflow = 1'b1;
    step();
    chk("s3_cleared", {63'd0, overflow}, 64'd0);
    word_valid = 1'b1;
    word_in = 16'h001A;
    step();
    word_valid = 1'b0;
    chk("s3_set_wins", {63'd0, overflow}, 64'd1);
    step();
    clear_overflow = 1'b0;
    chk("s3_cleared2", {63'd0, overflow}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("s3_payload2", payload_out, 64'h0018_0017_0016_0015);
    step();
    chk("s3_drained", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    // enable freeze mid-payload with a waiting payload
    for (int i = 8'h21; i <= 8'h24; i++) send(16'(i));
    send(16'h0031); send(16'h0032);
    enable = 1'b0;
    out_ready = 1'b1;
    word_valid = 1'b1;
    word_in = 16'h0EEE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_frz_valid", {63'd0, out_valid}, 64'd1);
      chk("s4_frz_payload", payload_out, 64'h0024_0023_0022_0021);
    end
    chk("s4_frz_ovf", {63'd0, overflow}, 64'd0);
    word_valid = 1'b0;
    enable = 1'b1;
    send(16'h0033);
    chk("s4_taken", {63'd0, out_valid}, 64'd0);
    send(16'h0034);
    chk("s4_resume_valid", {63'd0, out_valid}, 64'd1);
    chk("s4_resume_payload", payload_out, 64'h0034_0033_0032_0031);
    step();
    chk("s4_drained", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    // asynchronous reset mid-payload with out_valid and overflow set
    for (int i = 8'h41; i <= 8'h49; i++) send(16'(i));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(16'h0051); send(16'h0052);
    chk("s5_pre_valid", {63'd0, out_valid}, 64'd1);
    chk("s5_pre_payload", payload_out, 64'h0048_0047_0046_0045);
    chk("s5_pre_ovf", {63'd0, overflow}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("s5_rst_payload", payload_out, 64'd0);
    chk("s5_rst_ovf", {63'd0, overflow}, 64'd0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(16'h0061); send(16'h0062); send(16'h0063); send(16'h0064);
    chk("s5_clean_valid", {63'd0, out_valid}, 64'd1);
    chk("s5_clean_payload", payload_out, 64'h0064_0063_0062_0061);
    step();
    chk("s5_drained", {63'd0, out_valid}, 64'd0);
`ifdef STREAM_PACKER_FLUSH_EN
    send(16'hAAAA); send(16'hBBBB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f_valid", {63'd0, out_valid}, 64'd1);
    chk("f_payload", payload_out, 64'h0000_0000_BBBB_AAAA);
    step();
    chk("f_drained", {63'd0, out_valid}, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f_empty_noop", {63'd0, out_valid}, 64'd0);
    send(16'h0071); send(16'h0072); send(16'h0073); send(16'h0074);
    chk("f_full_payload", payload_out, 64'h0074_0073_0072_0071);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
